// File: rtl/move_entry_controller_if.sv
// move_entry_controller_if
//   Bundles the keypad/board inputs and the selection/cursor outputs of
//   move_entry_controller.
//   slave  : used by the controller (keys/board/turn in, selection out)
//   master : used by whatever drives keys and consumes the selection
//   Signals:
//     key_valid, key_code      one-cycle key event
//     board [x][y][3:0]        bit3 colour, [2:0]==0 means empty
//     turn                     side to move (0 white, 1 black)
//     cursorX, cursorY         cursor square
//     sel_valid                source square held
//     startX/startY/endX/endY  selected move
//     START                    one-cycle move request
//     busy                     high while a move is in flight
//     move_count               START pulses issued (wraps)
interface move_entry_controller_if;
   logic                  key_valid;
   logic [2:0]            key_code;
   logic [7:0][7:0][3:0]  board;
   logic                  turn;
   logic [2:0]            cursorX;
   logic [2:0]            cursorY;
   logic                  sel_valid;
   logic [2:0]            startX;
   logic [2:0]            startY;
   logic [2:0]            endX;
   logic [2:0]            endY;
   logic                  START;
   logic                  busy;
   logic [7:0]            move_count;

   modport master (
      output key_valid, key_code, board, turn,
      input  cursorX, cursorY, sel_valid, startX, startY, endX, endY, START, busy, move_count
   );

   modport slave (
      input  key_valid, key_code, board, turn,
      output cursorX, cursorY, sel_valid, startX, startY, endX, endY, START, busy, move_count
   );
endinterface

// File: rtl/move_entry_controller.sv
// move_entry_controller
//   Turns single-cycle keypad events into a source/destination square selection,
//   issues a one-cycle START with frozen coordinates, then ignores keys for
//   WAIT_CYCLES cycles while the downstream validator checks and applies the move.
//   Ports:
//     Clk    system clock (posedge)
//     Reset  synchronous, active-high
//     bus    move_entry_controller_if.slave (keys, board, turn in; cursor,
//            selection, START, busy, move_count out)
//   Parameters:
//     WAIT_CYCLES  1..15, cycles after START during which keys are dropped
//     CURSOR_WRAP  1 = cursor wraps 7<->0, 0 = cursor saturates at 0/7
//   Build option:
//     MOVE_ENTRY_RESELECT_EN  when defined, SELECT on another own piece while a
//                             source is held moves the source instead of
//                             issuing a move
module move_entry_controller #(
   parameter int unsigned WAIT_CYCLES = 3,
   parameter int unsigned CURSOR_WRAP = 1
) (
   input logic                     Clk,
   input logic                     Reset,
   move_entry_controller_if.slave  bus
);

   localparam logic [2:0] KeyUp     = 3'd1;
   localparam logic [2:0] KeyDown   = 3'd2;
   localparam logic [2:0] KeyLeft   = 3'd3;
   localparam logic [2:0] KeyRight  = 3'd4;
   localparam logic [2:0] KeySelect = 3'd5;
   localparam logic [2:0] KeyCancel = 3'd6;

   localparam logic [3:0] WaitLoad  = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {StPickSrc, StPickDst, StIssue, StWait} state_e;

   state_e     state_q, state_d;
   logic [2:0] cursor_x_q, cursor_x_d;
   logic [2:0] cursor_y_q, cursor_y_d;
   logic       sel_valid_q, sel_valid_d;
   logic [2:0] start_x_q, start_x_d;
   logic [2:0] start_y_q, start_y_d;
   logic [2:0] end_x_q, end_x_d;
   logic [2:0] end_y_q, end_y_d;
   logic       start_q, start_d;
   logic       busy_q, busy_d;
   logic [7:0] move_count_q, move_count_d;
   logic [3:0] wait_q, wait_d;

   logic [3:0] cur_square;
   logic       own_piece;
   logic       at_source;
   logic       reselect;

   function automatic logic [2:0] step_dec(input logic [2:0] v);
      if (v == 3'd0) return (CURSOR_WRAP != 0) ? 3'd7 : 3'd0;
      return v - 3'd1;
   endfunction

   function automatic logic [2:0] step_inc(input logic [2:0] v);
      if (v == 3'd7) return (CURSOR_WRAP != 0) ? 3'd0 : 3'd7;
      return v + 3'd1;
   endfunction

   assign cur_square = bus.board[cursor_x_q][cursor_y_q];
   assign own_piece  = (cur_square[2:0] != 3'd0) && (cur_square[3] == bus.turn);
   assign at_source  = (cursor_x_q == start_x_q) && (cursor_y_q == start_y_q);

`ifdef MOVE_ENTRY_RESELECT_EN
   assign reselect = own_piece;
`else
   // Own-piece destinations go downstream and are rejected there.
   assign reselect = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= StPickSrc;
         cursor_x_q   <= 3'd4;
         cursor_y_q   <= 3'd7;
         sel_valid_q  <= 1'b0;
         start_x_q    <= 3'd0;
         start_y_q    <= 3'd0;
         end_x_q      <= 3'd0;
         end_y_q      <= 3'd0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         move_count_q <= 8'd0;
         wait_q       <= 4'd0;
      end else begin
         state_q      <= state_d;
         cursor_x_q   <= cursor_x_d;
         cursor_y_q   <= cursor_y_d;
         sel_valid_q  <= sel_valid_d;
         start_x_q    <= start_x_d;
         start_y_q    <= start_y_d;
         end_x_q      <= end_x_d;
         end_y_q      <= end_y_d;
         start_q      <= start_d;
         busy_q       <= busy_d;
         move_count_q <= move_count_d;
         wait_q       <= wait_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cursor_x_d   = cursor_x_q;
      cursor_y_d   = cursor_y_q;
      sel_valid_d  = sel_valid_q;
      start_x_d    = start_x_q;
      start_y_d    = start_y_q;
      end_x_d      = end_x_q;
      end_y_d      = end_y_q;
      wait_d       = wait_q;

      unique case (state_q)
         StPickSrc, StPickDst: begin
            if (bus.key_valid) begin
               case (bus.key_code)
                  KeyUp:    cursor_y_d = step_dec(cursor_y_q);
                  KeyDown:  cursor_y_d = step_inc(cursor_y_q);
                  KeyLeft:  cursor_x_d = step_dec(cursor_x_q);
                  KeyRight: cursor_x_d = step_inc(cursor_x_q);
                  KeySelect: begin
                     if (state_q == StPickSrc) begin
                        if (own_piece) begin
                           start_x_d   = cursor_x_q;
                           start_y_d   = cursor_y_q;
                           sel_valid_d = 1'b1;
                           state_d     = StPickDst;
                        end
                     end else if (at_source) begin
                        sel_valid_d = 1'b0;
                        state_d     = StPickSrc;
                     end else if (reselect) begin
                        start_x_d = cursor_x_q;
                        start_y_d = cursor_y_q;
                     end else begin
                        end_x_d = cursor_x_q;
                        end_y_d = cursor_y_q;
                        state_d = StIssue;
                     end
                  end
                  KeyCancel: begin
                     if (state_q == StPickDst) begin
                        sel_valid_d = 1'b0;
                        state_d     = StPickSrc;
                     end
                  end
                  default: ;
               endcase
            end
         end
         StIssue: begin
            wait_d  = WaitLoad;
            state_d = StWait;
         end
         StWait: begin
            // Leaving on a count of 1 makes WAIT last exactly WaitLoad cycles.
            if (wait_q <= 4'd1) begin
               sel_valid_d = 1'b0;
               state_d     = StPickSrc;
            end
            if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
         end
         default: state_d = StPickSrc;
      endcase

      // Registered outputs derived from the next state so they line up with it.
      start_d      = (state_d == StIssue);
      busy_d       = (state_d == StIssue) || (state_d == StWait);
      move_count_d = move_count_q + {7'd0, start_d};
   end

   assign bus.cursorX    = cursor_x_q;
   assign bus.cursorY    = cursor_y_q;
   assign bus.sel_valid  = sel_valid_q;
   assign bus.startX     = start_x_q;
   assign bus.startY     = start_y_q;
   assign bus.endX       = end_x_q;
   assign bus.endY       = end_y_q;
   assign bus.START      = start_q;
   assign bus.busy       = busy_q;
   assign bus.move_count = move_count_q;

endmodule

// File: tb/tb_move_entry_controller.sv
// tb_move_entry_controller
//   Drives keypad events into a wrapping controller (WAIT_CYCLES=3) and a
//   saturating copy; every START is scored against a queue of expected moves.
module tb_move_entry_controller;

   localparam int unsigned Wait = 3;
   localparam logic [2:0] KUp = 3'd1, KDown = 3'd2, KLeft = 3'd3, KRight = 3'd4;
   localparam logic [2:0] KSel = 3'd5, KCancel = 3'd6;

   logic Clk = 1'b0;
   logic Reset;

   move_entry_controller_if wif ();
   move_entry_controller_if sif ();

   move_entry_controller #(.WAIT_CYCLES(Wait), .CURSOR_WRAP(1)) u_dut_wrap (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (wif)
   );

   move_entry_controller #(.WAIT_CYCLES(Wait), .CURSOR_WRAP(0)) u_dut_sat (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (sif)
   );

   assign sif.key_valid = wif.key_valid;
   assign sif.key_code  = wif.key_code;
   assign sif.board     = wif.board;
   assign sif.turn      = wif.turn;

   always #5 Clk = ~Clk;

   typedef struct {
      int sx;
      int sy;
      int ex;
      int ey;
   } move_t;

   move_t exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   logic  prev_start = 1'b0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Scoreboard: every START must match the oldest expected move.
   always @(negedge Clk) begin
      if (wif.START) begin
         check_eq("start_single_cycle", int'(prev_start), 0);
         if (exp_q.size() == 0) begin
            check_eq("unexpected_start", 1, 0);
         end else begin
            move_t m;
            m = exp_q.pop_front();
            check_eq("sb_startX", int'(wif.startX), m.sx);
            check_eq("sb_startY", int'(wif.startY), m.sy);
            check_eq("sb_endX",   int'(wif.endX),   m.ex);
            check_eq("sb_endY",   int'(wif.endY),   m.ey);
         end
      end
      prev_start <= wif.START;
   end

   task automatic push_move(input int sx, input int sy, input int ex, input int ey);
      move_t m;
      m.sx = sx; m.sy = sy; m.ex = ex; m.ey = ey;
      exp_q.push_back(m);
   endtask

   // Called at a negedge; the key is sampled on the next posedge.
   task automatic press(input logic [2:0] code);
      wif.key_valid = 1'b1;
      wif.key_code  = code;
      @(negedge Clk);
      wif.key_valid = 1'b0;
      wif.key_code  = 3'd0;
   endtask

   task automatic check_cursor(input string tag, input int x, input int y);
      check_eq({tag, "_cx"}, int'(wif.cursorX), x);
      check_eq({tag, "_cy"}, int'(wif.cursorY), y);
   endtask

   task automatic check_reset(input string tag);
      check_cursor(tag, 4, 7);
      check_eq({tag, "_sel"},    int'(wif.sel_valid),  0);
      check_eq({tag, "_start"},  int'(wif.START),      0);
      check_eq({tag, "_busy"},   int'(wif.busy),       0);
      check_eq({tag, "_count"},  int'(wif.move_count), 0);
      check_eq({tag, "_sx"},     int'(wif.startX),     0);
      check_eq({tag, "_sy"},     int'(wif.startY),     0);
      check_eq({tag, "_ex"},     int'(wif.endX),       0);
      check_eq({tag, "_ey"},     int'(wif.endY),       0);
   endtask

   // Counts cycles with busy high, starting at the current negedge.
   task automatic wait_idle(output int n);
      n = 0;
      while (wif.busy && n < 50) begin
         n++;
         @(negedge Clk);
      end
      if (n >= 50) check_eq("busy_timeout", 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [7:0][7:0][3:0] brd;
      brd = '0;
      brd[4][6] = 4'h1;  // white pawn
      brd[4][7] = 4'h6;  // white king
      brd[6][7] = 4'h2;  // white knight
      brd[1][7] = 4'h2;  // white knight
      brd[2][7] = 4'h3;  // white bishop
      brd[4][0] = 4'h9;  // black pawn
      wif.board     = brd;
      wif.turn      = 1'b0;
      wif.key_valid = 1'b0;
      wif.key_code  = 3'd0;
      Reset         = 1'b1;
      repeat (2) @(negedge Clk);
      check_reset("rst");
      check_eq("rst_sat_cx", int'(sif.cursorX), 4);
      Reset = 1'b0;

      // Cursor edge behaviour.
      repeat (4) press(KLeft);
      check_cursor("left4_wrap", 0, 7);
      check_eq("left4_sat_cx", int'(sif.cursorX), 0);
      press(KLeft);
      check_cursor("left5_wrap", 7, 7);
      check_eq("left5_sat_cx", int'(sif.cursorX), 0);
      check_eq("left5_sat_cy", int'(sif.cursorY), 7);
      repeat (5) press(KRight);
      check_cursor("back_home", 4, 7);

      // Full move (4,6)->(4,4).
      press(KUp);
      press(KSel);
      check_eq("src_sel", int'(wif.sel_valid), 1);
      check_eq("src_sx", int'(wif.startX), 4);
      check_eq("src_sy", int'(wif.startY), 6);
      press(KUp);
      press(KUp);
      check_cursor("dst", 4, 4);
      push_move(4, 6, 4, 4);
      press(KSel);
      check_eq("m1_start", int'(wif.START), 1);
      wait_idle(n);
      check_eq("m1_busy_cycles", n, 1 + Wait);
      check_eq("m1_sel_after", int'(wif.sel_valid), 0);
      check_eq("m1_count", int'(wif.move_count), 1);

      // Empty and opponent squares cannot be sources.
      press(KSel);
      check_eq("empty_sel", int'(wif.sel_valid), 0);
      repeat (4) press(KUp);
      check_cursor("opp", 4, 0);
      press(KSel);
      check_eq("opp_sel", int'(wif.sel_valid), 0);

      // Deselect by re-selecting the source, then cancel.
      press(KRight);
      press(KRight);
      press(KUp);
      check_cursor("knight", 6, 7);
      press(KSel);
      check_eq("kn_sel", int'(wif.sel_valid), 1);
      press(KSel);
      check_eq("kn_desel", int'(wif.sel_valid), 0);
      press(KSel);
      check_eq("kn_resel", int'(wif.sel_valid), 1);
      press(KCancel);
      check_eq("kn_cancel_sel", int'(wif.sel_valid), 0);
      check_eq("kn_cancel_sx", int'(wif.startX), 6);
      check_eq("kn_cancel_busy", int'(wif.busy), 0);

      // Keys during WAIT are dropped.
      press(KSel);
      press(KDown);
      push_move(6, 7, 6, 0);
      press(KSel);
      check_eq("m2_start", int'(wif.START), 1);
      press(KSel);
      check_eq("m2_no_restart", int'(wif.START), 0);
      check_eq("m2_busy", int'(wif.busy), 1);
      press(KCancel);
      press(KRight);
      check_cursor("m2_frozen", 6, 0);
      check_eq("m2_frozen_sx", int'(wif.startX), 6);
      check_eq("m2_frozen_ey", int'(wif.endY), 0);
      wait_idle(n);
      check_cursor("m2_after", 6, 0);
      check_eq("m2_sel_after", int'(wif.sel_valid), 0);
      check_eq("m2_count", int'(wif.move_count), 2);

      // Reset in the middle of WAIT.
      press(KUp);
      press(KSel);
      press(KDown);
      push_move(6, 7, 6, 0);
      press(KSel);
      check_eq("m3_start", int'(wif.START), 1);
      @(negedge Clk);
      check_eq("m3_busy", int'(wif.busy), 1);
      Reset = 1'b1;
      @(negedge Clk);
      check_reset("midrst");
      Reset = 1'b0;

      // Selecting another own piece while a source is held.
      repeat (3) press(KLeft);
      press(KSel);
      check_eq("rs_sel", int'(wif.sel_valid), 1);
      check_eq("rs_sx", int'(wif.startX), 1);
      press(KRight);
`ifdef MOVE_ENTRY_RESELECT_EN
      press(KSel);
      check_eq("rs_new_sx", int'(wif.startX), 2);
      check_eq("rs_new_sy", int'(wif.startY), 7);
      check_eq("rs_still_sel", int'(wif.sel_valid), 1);
      check_eq("rs_no_busy", int'(wif.busy), 0);
      press(KCancel);
      check_eq("rs_cancel", int'(wif.sel_valid), 0);
      check_eq("rs_count", int'(wif.move_count), 0);
`else
      push_move(1, 7, 2, 7);
      press(KSel);
      check_eq("rs_start", int'(wif.START), 1);
      wait_idle(n);
      check_eq("rs_busy_cycles", n, 1 + Wait);
      check_eq("rs_count", int'(wif.move_count), 1);
`endif

      repeat (2) @(negedge Clk);
      check_eq("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/move_entry_controller.md
Name: move_entry_controller

Overview:
- Upstream of the move-validation state machine.
- Turns single-cycle cursor/keypad events into a two-step square selection (source, then destination).
- Issues a one-cycle START pulse with stable startX/startY/endX/endY, then holds off input while the downstream checks and applies the move.
- Provides cursor and selection state for the board renderer.

Parameters:
- WAIT_CYCLES, 3, number of cycles after the START cycle during which coordinates stay frozen and keys are ignored (covers downstream CheckValid/MovePiece/Halted return); legal range 1–15.
- CURSOR_WRAP, 1, 1 = cursor wraps 7↔0 at board edges; 0 = cursor saturates at 0/7.

Ports:
- Clk  in  1  system clock, all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe, key_code valid this cycle
- key_code  in  3  0 none, 1 UP (y−1), 2 DOWN (y+1), 3 LEFT (x−1), 4 RIGHT (x+1), 5 SELECT, 6 CANCEL, 7 reserved (ignored)
- board  in  8x8x4  current board as [x][y][3:0]; bit3 colour (0 white, 1 black), [2:0]==0 empty
- turn  in  1  side to move (0 white, 1 black)
- cursorX, cursorY  out  3 each  current cursor square
- sel_valid  out  1  a source square is held
- startX, startY  out  3 each  held source square
- endX, endY  out  3 each  held destination square
- START  out  1  one-cycle move request
- busy  out  1  high in ISSUE and WAIT
- move_count  out  8  number of START pulses issued, wraps 255→0

Behaviour:
- All outputs registered. Reset values:
  - cursorX=4, cursorY=7.
  - sel_valid=0, START=0, busy=0, move_count=0.
  - startX/startY/endX/endY=0.
  - State=PICK_SRC, wait counter=0.
- Reset mid-operation (any state, including during WAIT) returns to these values the next cycle.
- Events are sampled only when key_valid=1. Effects are visible the cycle after the sampling edge.
- Cursor keys act in PICK_SRC and PICK_DST only.
  - Each key changes one coordinate by ±1.
  - At an edge: wraps (CURSOR_WRAP=1) or holds (CURSOR_WRAP=0).
- States:
  - PICK_SRC:
    - SELECT when board[cursorX][cursorY][2:0]!=0 and board[cursorX][cursorY][3]==turn: latch startX/startY=cursor, sel_valid=1, go to PICK_DST.
    - SELECT on an empty or opponent square: ignored, no state change.
    - CANCEL: no-op.
  - PICK_DST:
    - SELECT with cursor==(startX,startY): deselect, sel_valid=0, go to PICK_SRC.
    - SELECT on any other square: latch endX/endY=cursor, go to ISSUE.
    - CANCEL: sel_valid=0, go to PICK_SRC. startX/startY retain their last value.
  - ISSUE (exactly 1 cycle):
    - START=1, busy=1, move_count+=1.
    - Load wait counter with WAIT_CYCLES, go to WAIT.
  - WAIT:
    - busy=1, START=0; counter decrements each cycle.
    - When the counter reaches 1, go to PICK_SRC with sel_valid=0.
    - WAIT lasts exactly WAIT_CYCLES cycles.
- startX/startY/endX/endY are stable from the ISSUE cycle through the last WAIT cycle, and change only on the latching SELECT events.
- All key events, including CANCEL, are dropped while busy=1. They are not queued.
- Latency: SELECT (destination) sampled at edge N → START high during cycle N+1 → busy low at cycle N+2+WAIT_CYCLES.
- Move legality is not checked here beyond source ownership; illegal moves are rejected downstream.
- turn is sampled at the same edge as the source SELECT. The downstream toggles turn only in MovePiece, which occurs during WAIT.
- Downstream START requirement: START asserts only in ISSUE, never on two consecutive cycles.

Optional Feature:
- Macro MOVE_ENTRY_RESELECT_EN.
- Defined: in PICK_DST, SELECT on a square holding a turn-coloured piece other than the current source re-latches startX/startY=cursor and stays in PICK_DST. No START is issued.
- Undefined: that SELECT is treated as a destination and goes to ISSUE. The downstream validator rejects it as an own-piece capture.

Test Plan:
- Reset, then 4×LEFT with CURSOR_WRAP=1 → cursor (0,7); one more LEFT → (7,7). With CURSOR_WRAP=0, 5×LEFT from (4,7) → (0,7).
- turn=0, white pawn at (4,6): UP, SELECT, UP, UP, SELECT → START high exactly one cycle with start=(4,6), end=(4,4); move_count=1; busy high for 1+WAIT_CYCLES cycles; then sel_valid=0, state PICK_SRC.
- turn=0, cursor on black piece at (4,0): SELECT → sel_valid stays 0. Cursor on empty (4,4): SELECT → sel_valid stays 0.
- Source (6,7) selected: SELECT at (6,7) → sel_valid=0. Reselect source, then CANCEL → sel_valid=0, no START.
- During WAIT, inject SELECT/CANCEL/RIGHT → cursor and outputs unchanged, no second START. Assert Reset during WAIT → next cycle all outputs at reset values.
- Source (1,7) selected, SELECT on white piece at (2,7): macro defined → start=(2,7), no START; macro undefined → START with start=(1,7), end=(2,7).
